// File: rtl/mem_port_arb.sv
// mem_port_arb: round-robin arbiter that serialises 1-4 byte requests
// from NUM_PORTS clients onto a byte-wide RAM/IO bus.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global stall; freezes grant, issue and FSM state
//   req_valid/write/len/addr/wdata  per-port request bundles (packed)
//   req_ready       one-hot accept strobe (combinational grant)
//   resp_valid      one-hot completion pulse, resp_rdata shared data
//   mem_din/dout/a/wr  external byte bus
//   busy            transfer in progress (RUN or TAIL)

module mem_port_arb #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rdy,
   input  logic [NUM_PORTS-1:0]        req_valid,
   input  logic [NUM_PORTS-1:0]        req_write,
   input  logic [2*NUM_PORTS-1:0]      req_len,
   input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
   input  logic [32*NUM_PORTS-1:0]     req_wdata,
   output logic [NUM_PORTS-1:0]        req_ready,
   output logic [NUM_PORTS-1:0]        resp_valid,
   output logic [31:0]                 resp_rdata,
   input  logic [7:0]                  mem_din,
   output logic [7:0]                  mem_dout,
   output logic [31:0]                 mem_a,
   output logic                        mem_wr,
   output logic                        busy
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

   state_t               state;
   logic [IDX_W-1:0]     last_g;
   logic [IDX_W-1:0]     cur_g;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_any;
   logic                 wr_q;
   logic [1:0]           len_q;
   logic [1:0]           idx_q;
   logic [ADDR_W-1:0]    a_q;
   logic [23:0]          wd_q;
   logic [7:0]           dout_q;
   logic [NUM_PORTS-1:0] resp_q;
   logic [31:0]          rd_q;
   logic [31:0]          rd_next;
   logic [31:0]          rdata_q;
   logic                 cap_pend;
   logic [1:0]           cap_slot;

   logic                 sel_write;
   logic [1:0]           sel_len;
   logic [ADDR_W-1:0]    sel_addr;
   logic [31:0]          sel_wdata;
   logic [31:0]          wdm;

   // First valid port strictly after last_g; scanning from the far end
   // lets the nearest candidate overwrite the others.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         if (req_valid[(int'(last_g) + k) % NUM_PORTS]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'((int'(last_g) + k) % NUM_PORTS);
         end
      end
   end

   always_comb begin
      sel_write = req_write[gnt_idx];
      sel_len   = req_len[2*int'(gnt_idx) +: 2];
      sel_addr  = req_addr[ADDR_W*int'(gnt_idx) +: ADDR_W];
      sel_wdata = req_wdata[32*int'(gnt_idx) +: 32];
      wdm       = sel_write ? sel_wdata : 32'h0;
   end

   // A byte issued last cycle arrives on mem_din now; merge it in.
   always_comb begin
      rd_next = rd_q;
      if (cap_pend) begin
         rd_next[8*cap_slot +: 8] = mem_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_g   <= IDX_W'(NUM_PORTS - 1);
         cur_g    <= '0;
         wr_q     <= 1'b0;
         len_q    <= 2'd0;
         idx_q    <= 2'd0;
         a_q      <= '0;
         wd_q     <= '0;
         dout_q   <= '0;
         resp_q   <= '0;
         rd_q     <= '0;
         rdata_q  <= '0;
         cap_pend <= 1'b0;
         cap_slot <= 2'd0;
      end else begin
         // RAM answers regardless of rdy, so capture is never stalled.
         cap_pend <= 1'b0;
         if (cap_pend) begin
            rd_q <= rd_next;
         end
         if (rdy) begin
            resp_q <= '0;
            unique case (state)
               IDLE: begin
                  if (gnt_any) begin
                     state  <= RUN;
                     last_g <= gnt_idx;
                     cur_g  <= gnt_idx;
                     wr_q   <= sel_write;
                     len_q  <= sel_len;
                     idx_q  <= 2'd0;
                     a_q    <= sel_addr;
                     dout_q <= wdm[7:0];
                     wd_q   <= wdm[31:8];
                     rd_q   <= '0;
                  end
               end
               RUN: begin
                  if (!wr_q) begin
                     cap_pend <= 1'b1;
                     cap_slot <= idx_q;
                  end
                  if (idx_q == len_q) begin
                     wr_q   <= 1'b0;
                     dout_q <= '0;
                     if (wr_q) begin
                        state   <= IDLE;
                        resp_q  <= NUM_PORTS'(1) << cur_g;
                        rdata_q <= '0;
                     end else begin
                        state <= TAIL;
                     end
                  end else begin
                     idx_q  <= idx_q + 2'd1;
                     a_q    <= a_q + ADDR_W'(1);
                     dout_q <= wd_q[7:0];
                     wd_q   <= {8'h00, wd_q[23:8]};
                  end
               end
               TAIL: begin
                  state   <= IDLE;
                  resp_q  <= NUM_PORTS'(1) << cur_g;
                  rdata_q <= rd_next;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && rdy && !rst && gnt_any) begin
         req_ready = NUM_PORTS'(1) << gnt_idx;
      end
   end

   assign resp_valid = resp_q & {NUM_PORTS{rdy}};
   assign resp_rdata = rdata_q;
   assign mem_dout   = dout_q;
   assign mem_a      = 32'(a_q);
   assign mem_wr     = wr_q & rdy;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: randomized and directed checks of mem_port_arb
// against a transaction-level model of bus timing and memory contents.

module tb_mem_port_arb;

   localparam int NP = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            rdy;
   logic [NP-1:0]   req_valid;
   logic [NP-1:0]   req_write;
   logic [2*NP-1:0] req_len;
   logic [32*NP-1:0] req_addr;
   logic [32*NP-1:0] req_wdata;
   logic [NP-1:0]   req_ready;
   logic [NP-1:0]   resp_valid;
   logic [31:0]     resp_rdata;
   logic [7:0]      mem_din;
   logic [7:0]      mem_dout;
   logic [31:0]     mem_a;
   logic            mem_wr;
   logic            busy;

   int checks = 0;
   int failures = 0;

   bit [7:0] bus_ram [bit [31:0]];
   bit [7:0] ref_mem [bit [31:0]];

   logic [31:0]   ob_a  [0:63];
   logic          ob_wr [0:63];
   logic [7:0]    ob_do [0:63];
   logic [NP-1:0] ob_rv [0:63];

   mem_port_arb #(.NUM_PORTS(NP), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .req_valid(req_valid), .req_write(req_write),
      .req_len(req_len), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous byte RAM: data for the address seen this cycle
   // appears on mem_din in the next cycle.
   always @(posedge clk) begin
      if (mem_wr === 1'b1) bus_ram[mem_a] = mem_dout;
      mem_din <= bus_ram.exists(mem_a) ? bus_ram[mem_a] : 8'h00;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic void preload(input logic [31:0] a, input logic [7:0] d);
      bus_ram[a] = d;
      ref_mem[a] = d;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a, input int len);
      logic [31:0] r = 32'h0;
      for (int j = 0; j <= len; j++) r[8*j +: 8] = ref_rd(a + 32'(j));
      return r;
   endfunction

   // Drives one request and records the bus per cycle after accept.
   // rdy is dropped for stall_n cycles starting at offset stall_at.
   task automatic run_txn(input int port, input bit wr, input int len,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int stall_at, input int stall_n,
                          output bit to, output int roff,
                          output logic [NP-1:0] rvec, output logic [31:0] rdat);
      bit got = 1'b0;
      to = 1'b0; roff = -1; rvec = '0; rdat = '0;
      @(negedge clk);
      req_valid[port] = 1'b1;
      req_write[port] = wr;
      req_len[2*port +: 2] = 2'(len);
      req_addr[32*port +: 32] = addr;
      req_wdata[32*port +: 32] = wd;
      for (int w = 0; w < 20; w++) begin
         #1;
         if (req_ready[port] === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      if (!got) begin
         req_valid[port] = 1'b0;
         to = 1'b1;
         return;
      end
      @(posedge clk); #1;
      req_valid[port] = 1'b0;
      for (int k = 1; k < 40; k++) begin
         if (stall_n > 0 && k == stall_at) rdy = 1'b0;
         if (stall_n > 0 && k == stall_at + stall_n) rdy = 1'b1;
         @(negedge clk);
         ob_a[k] = mem_a; ob_wr[k] = mem_wr;
         ob_do[k] = mem_dout; ob_rv[k] = resp_valid;
         if (resp_valid !== '0) begin
            roff = k; rvec = resp_valid; rdat = resp_rdata;
            break;
         end
         @(posedge clk); #1;
      end
      rdy = 1'b1;
      if (roff < 0) to = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1;
      req_valid = '0; req_write = '0; req_len = '0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      checks++; if (mem_a !== 32'h0) begin failures++; $display("FAIL reset mem_a: got %h want 0", mem_a); end
      checks++; if (mem_dout !== 8'h0) begin failures++; $display("FAIL reset mem_dout: got %h want 0", mem_dout); end
      checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset mem_wr: got %b want 0", mem_wr); end
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset req_ready: got %b want 0", req_ready); end
      checks++; if (resp_valid !== '0) begin failures++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset resp_rdata: got %h want 0", resp_rdata); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      bit to; int ro; logic [NP-1:0] rv; logic [31:0] rd;
      preload(32'h100, 8'h11); preload(32'h101, 8'h22);
      preload(32'h102, 8'h33); preload(32'h103, 8'h44);
      run_txn(0, 1'b0, 3, 32'h100, 32'h0, 0, 0, to, ro, rv, rd);
      checks++;
      if (to) begin failures++; $display("FAIL single_read timeout"); return; end
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (ob_a[k] !== 32'h100 + 32'(k-1) || ob_wr[k] !== 1'b0) begin
            failures++;
            $display("FAIL single_read bus[%0d]: got a=%h wr=%b want a=%h wr=0", k, ob_a[k], ob_wr[k], 32'h100 + 32'(k-1));
         end
      end
      checks++; if (ro !== 6) begin failures++; $display("FAIL single_read latency: got %0d want 6", ro); end
      checks++; if (rv !== 3'b001) begin failures++; $display("FAIL single_read resp_valid: got %b want 001", rv); end
      checks++; if (rd !== 32'h44332211) begin failures++; $display("FAIL single_read rdata: got %h want 44332211", rd); end
   endtask

   task automatic test_half_write();
      bit to; int ro; logic [NP-1:0] rv; logic [31:0] rd;
      run_txn(1, 1'b1, 1, 32'h30000, 32'hDEADBEEF, 0, 0, to, ro, rv, rd);
      checks++;
      if (to) begin failures++; $display("FAIL half_write timeout"); return; end
      checks++;
      if (ob_wr[1] !== 1'b1 || ob_a[1] !== 32'h30000 || ob_do[1] !== 8'hEF) begin
         failures++;
         $display("FAIL half_write byte0: got wr=%b a=%h d=%h want 1 30000 ef", ob_wr[1], ob_a[1], ob_do[1]);
      end
      checks++;
      if (ob_wr[2] !== 1'b1 || ob_a[2] !== 32'h30001 || ob_do[2] !== 8'hBE) begin
         failures++;
         $display("FAIL half_write byte1: got wr=%b a=%h d=%h want 1 30001 be", ob_wr[2], ob_a[2], ob_do[2]);
      end
      checks++; if (ro !== 3) begin failures++; $display("FAIL half_write latency: got %0d want 3", ro); end
      checks++; if (rv !== 3'b010) begin failures++; $display("FAIL half_write resp_valid: got %b want 010", rv); end
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL half_write rdata: got %h want 0", rd); end
      ref_mem[32'h30000] = 8'hEF;
      ref_mem[32'h30001] = 8'hBE;
   endtask

   task automatic test_rdy_freeze();
      bit to; int ro; logic [NP-1:0] rv; logic [31:0] rd;
      logic [31:0] ea [1:9];
      preload(32'h200, 8'hA1); preload(32'h201, 8'hB2);
      preload(32'h202, 8'hC3); preload(32'h203, 8'hD4);
      ea[1] = 32'h200; ea[2] = 32'h201;
      for (int k = 3; k <= 7; k++) ea[k] = 32'h202;
      ea[8] = 32'h203; ea[9] = 32'h203;
      run_txn(0, 1'b0, 3, 32'h200, 32'h0, 3, 4, to, ro, rv, rd);
      checks++;
      if (to) begin failures++; $display("FAIL rdy_freeze timeout"); return; end
      checks++; if (ro !== 10) begin failures++; $display("FAIL rdy_freeze latency: got %0d want 10", ro); end
      for (int k = 1; k <= 9 && k < ro; k++) begin
         checks++;
         if (ob_a[k] !== ea[k] || ob_wr[k] !== 1'b0 || ob_rv[k] !== '0) begin
            failures++;
            $display("FAIL rdy_freeze bus[%0d]: got a=%h wr=%b rv=%b want a=%h wr=0 rv=0", k, ob_a[k], ob_wr[k], ob_rv[k], ea[k]);
         end
      end
      checks++; if (rd !== 32'hD4C3B2A1) begin failures++; $display("FAIL rdy_freeze rdata: got %h want d4c3b2a1", rd); end
   endtask

   task automatic test_wrap();
      bit to; int ro; logic [NP-1:0] rv; logic [31:0] rd;
      logic [31:0] ea [0:3];
      ea[0] = 32'hFFFFFFFE; ea[1] = 32'hFFFFFFFF;
      ea[2] = 32'h00000000; ea[3] = 32'h00000001;
      for (int j = 0; j < 4; j++) preload(ea[j], 8'(8'h5A + j));
      run_txn(2, 1'b0, 3, 32'hFFFFFFFE, 32'h0, 0, 0, to, ro, rv, rd);
      checks++;
      if (to) begin failures++; $display("FAIL wrap timeout"); return; end
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (ob_a[k] !== ea[k-1]) begin
            failures++;
            $display("FAIL wrap addr[%0d]: got %h want %h", k, ob_a[k], ea[k-1]);
         end
      end
      checks++; if (rd !== 32'h5D5C5B5A) begin failures++; $display("FAIL wrap rdata: got %h want 5d5c5b5a", rd); end
   endtask

   task automatic test_random();
      bit to; int ro; logic [NP-1:0] rv; logic [31:0] rd;
      for (int a = 0; a < 32; a++) preload(32'h1000 + 32'(a), 8'($urandom));
      for (int t = 0; t < 40; t++) begin
         int p = $urandom_range(0, NP-1);
         bit w = 1'($urandom_range(0, 1));
         int n = $urandom_range(0, 3);
         logic [31:0] ad = 32'h1000 + 32'($urandom_range(0, 28));
         logic [31:0] wd = $urandom;
         logic [31:0] erd = w ? 32'h0 : exp_read(ad, n);
         int elat = w ? n + 2 : n + 3;
         run_txn(p, w, n, ad, wd, 0, 0, to, ro, rv, rd);
         checks++;
         if (to) begin failures++; $display("FAIL random[%0d] timeout", t); continue; end
         for (int k = 1; k <= n + 1; k++) begin
            logic [7:0] ed = w ? wd[8*(k-1) +: 8] : 8'h00;
            checks++;
            if (ob_a[k] !== ad + 32'(k-1) || ob_wr[k] !== w || ob_do[k] !== ed) begin
               failures++;
               $display("FAIL random[%0d] bus[%0d]: got a=%h wr=%b d=%h want a=%h wr=%b d=%h",
                        t, k, ob_a[k], ob_wr[k], ob_do[k], ad + 32'(k-1), w, ed);
            end
         end
         checks++; if (ro !== elat) begin failures++; $display("FAIL random[%0d] latency: got %0d want %0d", t, ro, elat); end
         checks++; if (rv !== NP'(1) << p) begin failures++; $display("FAIL random[%0d] resp_valid: got %b want port %0d", t, rv, p); end
         checks++; if (rd !== erd) begin failures++; $display("FAIL random[%0d] rdata: got %h want %h", t, rd, erd); end
         if (w) for (int j = 0; j <= n; j++) ref_mem[ad + 32'(j)] = wd[8*j +: 8];
      end
   endtask

   task automatic test_round_robin();
      int acc_p [0:5];
      int acc_c [0:5];
      logic [NP-1:0] acc_rv [0:5];
      int nacc = 0;
      int exp_p = NP - 1;
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int p = 0; p < NP; p++) begin
         req_valid[p] = 1'b1; req_write[p] = 1'b1;
         req_len[2*p +: 2] = 2'd0;
         req_addr[32*p +: 32] = 32'h5000 + 32'(p);
         req_wdata[32*p +: 32] = 32'(p + 1);
      end
      for (int c = 0; c < 40 && nacc < 6; c++) begin
         #1;
         if (req_ready !== '0) begin
            acc_p[nacc] = -1;
            for (int p = 0; p < NP; p++) if (req_ready === NP'(1) << p) acc_p[nacc] = p;
            acc_c[nacc] = c;
            acc_rv[nacc] = resp_valid;
            nacc++;
         end
         @(negedge clk);
      end
      req_valid = '0;
      checks++;
      if (nacc !== 6) begin failures++; $display("FAIL round_robin accepts: got %0d want 6", nacc); end
      for (int i = 0; i < nacc; i++) begin
         exp_p = (exp_p + 1) % NP;
         checks++;
         if (acc_p[i] !== exp_p) begin failures++; $display("FAIL round_robin grant[%0d]: got %0d want %0d", i, acc_p[i], exp_p); end
         if (i > 0) begin
            checks++;
            if (acc_c[i] - acc_c[i-1] !== 2) begin
               failures++;
               $display("FAIL round_robin spacing[%0d]: got %0d want 2", i, acc_c[i] - acc_c[i-1]);
            end
            checks++;
            if (acc_rv[i] !== NP'(1) << ((exp_p + NP - 1) % NP)) begin
               failures++;
               $display("FAIL round_robin resp_with_grant[%0d]: got %b want port %0d", i, acc_rv[i], (exp_p + NP - 1) % NP);
            end
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid_read();
      bit got = 1'b0;
      bit seen = 1'b0;
      @(negedge clk);
      req_valid[1] = 1'b1; req_write[1] = 1'b0;
      req_len[3:2] = 2'd3; req_addr[63:32] = 32'h100;
      for (int w = 0; w < 20; w++) begin
         #1;
         if (req_ready[1] === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!got) begin failures++; $display("FAIL reset_mid grant timeout"); end
      @(posedge clk); #1; req_valid[1] = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_wr !== 1'b0 || busy !== 1'b0 ||
          resp_valid !== '0 || resp_rdata !== 32'h0 || req_ready !== '0) begin
         failures++;
         $display("FAIL reset_mid outputs: got a=%h d=%h wr=%b busy=%b rv=%b rd=%h rr=%b want all 0",
                  mem_a, mem_dout, mem_wr, busy, resp_valid, resp_rdata, req_ready);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (resp_valid !== '0) seen = 1'b1;
      end
      checks++;
      if (seen) begin failures++; $display("FAIL reset_mid resp: got pulse want none"); end
      for (int p = 0; p < NP; p++) begin
         req_valid[p] = 1'b1; req_write[p] = 1'b0;
         req_len[2*p +: 2] = 2'd0;
      end
      #1;
      checks++;
      if (req_ready !== 3'b001) begin failures++; $display("FAIL reset_mid next_grant: got %b want 001", req_ready); end
      @(posedge clk); #1; req_valid = '0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_half_write();
      test_rdy_freeze();
      test_wrap();
      test_random();
      test_round_robin();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
